// File: rtl/drum_pkg.sv
// drum_pkg: shared 1.17 fixed-point type, tension constants and multiply helper
package drum_pkg;
  typedef logic signed [17:0] fix18_t;
  localparam fix18_t FIX_ONE = 18'sh1FFFF;
  localparam fix18_t RHO_INIT_DEF = 18'sd6553;
  localparam fix18_t RHO_MAX_DEF = 18'sd62914;
  function automatic fix18_t mult_1_17(fix18_t a, fix18_t b);
    logic signed [35:0] p;
    p = a * b;
    return {p[35], p[33:17]};
  endfunction
endpackage

// File: rtl/drum_sample_fifo.sv
// drum_sample_fifo: centre-sample FIFO with ready/valid drain and synchronous flush
module drum_sample_fifo #(
  parameter int DEPTH = 8,
  parameter int W = 18
) (
  input  logic                     clk_50,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  output logic [W-1:0]             audio_data,
  output logic                     audio_valid,
  input  logic                     audio_ready,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_pop, do_push;
  assign do_pop = audio_valid && audio_ready;
  assign do_push = push && (!full || do_pop);
  assign audio_valid = count != '0;
  assign full = count == FULL_CNT;
  assign audio_data = audio_valid ? mem[rd_ptr] : '0;
  always_ff @(posedge clk_50) if (do_push) mem[wr_ptr] <= push_data;
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
    end
  end
endmodule

// File: rtl/drum_center_tap.sv
// drum_center_tap: captures the grid centre node, pipelines the tension update and buffers audio samples
module drum_center_tap
  import drum_pkg::*;
#(
  parameter int SIZE = 4,
  parameter int DEPTH = 8,
  parameter int RHO_SHIFT = 5,
  parameter fix18_t RHO_INIT = RHO_INIT_DEF,
  parameter fix18_t RHO_MAX = RHO_MAX_DEF
) (
  input  logic   clk_50,
  input  logic   rst_n,
  input  logic   restart,
  input  logic   iter_done,
  input  fix18_t center_node,
  output fix18_t rho,
  output logic   rho_valid,
  output logic   grid_enable,
  output fix18_t audio_data,
  output logic   audio_valid,
  input  logic   audio_ready,
  output logic   overrun
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] GE_CNT = (AW + 1)'(DEPTH - 1);
  if (SIZE < 2 || DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_param
    $error("drum_center_tap: SIZE must be >=2 and DEPTH a power of two >=4");
  end
  fix18_t c_q, sq_q, sq_sh, rho_nxt;
  logic v0, v1, push, full;
  logic signed [18:0] sum;
  logic [AW:0] count;
  assign push = iter_done && !restart;
  assign sq_sh = sq_q >>> RHO_SHIFT;
  assign sum = $signed({RHO_INIT[17], RHO_INIT}) + $signed({sq_sh[17], sq_sh});
  assign rho_nxt = (sum > $signed({RHO_MAX[17], RHO_MAX})) ? RHO_MAX : sum[17:0];
  always_ff @(posedge clk_50 or negedge rst_n) begin
    if (!rst_n) begin
      c_q <= '0;
      sq_q <= '0;
      v0 <= 1'b0;
      v1 <= 1'b0;
      rho <= RHO_INIT;
      rho_valid <= 1'b0;
      grid_enable <= 1'b1;
      overrun <= 1'b0;
    end else begin
      c_q <= center_node;
      sq_q <= mult_1_17(c_q, c_q);
      v0 <= push;
      v1 <= v0 && !restart;
      rho_valid <= v1 && !restart;
      grid_enable <= count < GE_CNT;
      if (restart) begin
        rho <= RHO_INIT;
        overrun <= 1'b0;
      end else begin
        if (v1) rho <= rho_nxt;
        if (push && full && !(audio_valid && audio_ready)) overrun <= 1'b1;
      end
    end
  end
  drum_sample_fifo #(.DEPTH(DEPTH), .W(18)) u_fifo (
    .clk_50      (clk_50),
    .rst_n       (rst_n),
    .flush       (restart),
    .push        (push),
    .push_data   (center_node),
    .audio_data  (audio_data),
    .audio_valid (audio_valid),
    .audio_ready (audio_ready),
    .full        (full),
    .count       (count)
  );
endmodule

// File: tb/tb_drum_center_tap.sv
// tb_drum_center_tap: randomized and directed checks of drum_center_tap against a queue-based model
module tb_drum_center_tap;
  import drum_pkg::*;
  localparam int DEPTH = 8;
  logic clk_50 = 1'b0, rst_n = 1'b0, restart = 1'b0, iter_done = 1'b0, audio_ready = 1'b0;
  fix18_t center_node = '0;
  fix18_t rho, audio_data, rho2, audio_data2;
  logic rho_valid, grid_enable, audio_valid, overrun;
  logic rho_valid2, grid_enable2, audio_valid2, overrun2;
  int tests = 0, fails = 0;
  typedef struct {int due; int v; int v2;} pend_t;
  pend_t pend[$];
  int exp_q[$];
  int rho_m = 6553, rho2_m = 6553, cyc_n = 0;
  bit rv_m = 0, ovr_m = 0, ge_m = 1;

  always #10 clk_50 = ~clk_50;

  drum_center_tap dut (
    .clk_50(clk_50), .rst_n(rst_n), .restart(restart), .iter_done(iter_done),
    .center_node(center_node), .rho(rho), .rho_valid(rho_valid), .grid_enable(grid_enable),
    .audio_data(audio_data), .audio_valid(audio_valid), .audio_ready(audio_ready), .overrun(overrun)
  );
  drum_center_tap #(.RHO_SHIFT(1)) dut2 (
    .clk_50(clk_50), .rst_n(rst_n), .restart(restart), .iter_done(iter_done),
    .center_node(center_node), .rho(rho2), .rho_valid(rho_valid2), .grid_enable(grid_enable2),
    .audio_data(audio_data2), .audio_valid(audio_valid2), .audio_ready(audio_ready), .overrun(overrun2)
  );

  function automatic int rho_of(int c, int sh);
    longint p = longint'(c) * longint'(c);
    longint sq = (p >> 17) & 64'h1FFFF;
    longint s = 6553 + (sq >> sh);
    return (s > 62914) ? 62914 : int'(s);
  endfunction

  task automatic drive(input bit id, input int c, input bit rdy, input bit rs);
    int prev, cs;
    bit pop;
    fix18_t cf;
    cf = 18'(c);
    cs = int'(cf);
    iter_done = id; center_node = cf; audio_ready = rdy; restart = rs;
    prev = exp_q.size();
    ge_m = prev < DEPTH - 1;
    rv_m = 0;
    if (rs) begin
      exp_q.delete(); pend.delete();
      rho_m = 6553; rho2_m = 6553; ovr_m = 0;
    end else begin
      pop = prev > 0 && rdy;
      if (pop) void'(exp_q.pop_front());
      if (id) begin
        if (prev < DEPTH || pop) exp_q.push_back(cs);
        else ovr_m = 1;
      end
      if (pend.size() > 0 && pend[0].due == cyc_n) begin
        rho_m = pend[0].v; rho2_m = pend[0].v2; rv_m = 1;
        void'(pend.pop_front());
      end
      if (id) pend.push_back(pend_t'{cyc_n + 2, rho_of(cs, 5), rho_of(cs, 1)});
    end
    cyc_n++;
    @(posedge clk_50); #1;
    iter_done = 0; restart = 0;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk_50);
    #1;
    tests += 6;
    if (rho !== 18'sd6553) begin fails++; $display("FAIL reset_rho: got %0d want 6553", rho); end
    if (grid_enable !== 1'b1) begin fails++; $display("FAIL reset_ge: got %b want 1", grid_enable); end
    if (audio_valid !== 1'b0) begin fails++; $display("FAIL reset_av: got %b want 0", audio_valid); end
    if (overrun !== 1'b0) begin fails++; $display("FAIL reset_ovr: got %b want 0", overrun); end
    if (rho_valid !== 1'b0) begin fails++; $display("FAIL reset_rv: got %b want 0", rho_valid); end
    if (audio_data !== '0) begin fails++; $display("FAIL reset_ad: got %0d want 0", audio_data); end
    rst_n = 1'b1;
    @(posedge clk_50); #1;
  endtask

  task automatic test_basic();
    for (int i = 0; i < 4; i++) begin
      drive(i == 0, 65536, i != 0, 0);
      tests++;
      if (rho_valid !== (i == 2)) begin fails++; $display("FAIL basic_rv%0d: got %b want %b", i, rho_valid, i == 2); end
      if (i == 0) begin
        tests++;
        if (audio_valid !== 1'b1 || audio_data !== 18'sd65536) begin
          fails++; $display("FAIL basic_first_word: got v=%b d=%0d want v=1 d=65536", audio_valid, audio_data);
        end
      end
    end
    tests++;
    if (rho !== 18'sd7577) begin fails++; $display("FAIL basic_rho: got %0d want 7577", rho); end
  endtask

  task automatic test_square_clamp();
    for (int i = 0; i < 3; i++) drive(i == 0, 'h1FFFF, 1, 0);
    tests += 3;
    if (rho_valid !== 1'b1) begin fails++; $display("FAIL max_rv: got %b want 1", rho_valid); end
    if (rho !== 18'sd10648) begin fails++; $display("FAIL max_rho: got %0d want 10648", rho); end
    if (rho2 !== 18'sd62914) begin fails++; $display("FAIL clamp_rho: got %0d want 62914", rho2); end
    for (int i = 0; i < 3; i++) drive(i == 0, 'h20000, 1, 0);
    tests += 3;
    if (rho_valid !== 1'b1) begin fails++; $display("FAIL neg1_rv: got %b want 1", rho_valid); end
    if (rho !== 18'sd6553) begin fails++; $display("FAIL neg1_rho: got %0d want 6553", rho); end
    if (rho2 !== 18'sd6553) begin fails++; $display("FAIL neg1_rho2: got %0d want 6553", rho2); end
    drive(0, 0, 1, 0);
  endtask

  task automatic test_full();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, i * 1000 + 1, 0, 0);
      drive(0, 0, 0, 0);
      if (i == 5 || i == 6) begin
        tests++;
        if (grid_enable !== (i == 5)) begin fails++; $display("FAIL full_ge%0d: got %b want %b", i, grid_enable, i == 5); end
      end
    end
    tests += 2;
    if (audio_valid !== 1'b1 || audio_data !== 18'sd1) begin fails++; $display("FAIL full_head: got v=%b d=%0d want v=1 d=1", audio_valid, audio_data); end
    if (overrun !== 1'b0) begin fails++; $display("FAIL full_ovr0: got %b want 0", overrun); end
    drive(1, 12345, 0, 0);
    drive(0, 0, 0, 0);
    tests += 2;
    if (overrun !== 1'b1) begin fails++; $display("FAIL full_ovr1: got %b want 1", overrun); end
    if (audio_data !== 18'sd1) begin fails++; $display("FAIL full_drop_head: got %0d want 1", audio_data); end
  endtask

  task automatic test_back_to_back();
    drive(1, 777, 1, 0);
    tests += 3;
    if (audio_data !== 18'sd1001) begin fails++; $display("FAIL b2b_head: got %0d want 1001", audio_data); end
    if (overrun !== 1'b1) begin fails++; $display("FAIL b2b_ovr: got %b want 1", overrun); end
    if (grid_enable !== 1'b0) begin fails++; $display("FAIL b2b_ge: got %b want 0", grid_enable); end
    for (int i = 0; i < DEPTH; i++) begin
      tests++;
      if (audio_valid !== 1'b1 || int'(audio_data) !== exp_q[0]) begin
        fails++; $display("FAIL b2b_drain%0d: got v=%b d=%0d want v=1 d=%0d", i, audio_valid, audio_data, exp_q[0]);
      end
      drive(0, 0, 1, 0);
    end
    tests++;
    if (audio_valid !== 1'b0) begin fails++; $display("FAIL b2b_empty: got %b want 0", audio_valid); end
  endtask

  task automatic test_restart();
    drive(1, 65536, 0, 0);
    drive(1, 'h1FFFF, 0, 0);
    drive(1, 40000, 0, 1);
    tests += 4;
    if (audio_valid !== 1'b0) begin fails++; $display("FAIL rs_av: got %b want 0", audio_valid); end
    if (rho !== 18'sd6553) begin fails++; $display("FAIL rs_rho: got %0d want 6553", rho); end
    if (rho_valid !== 1'b0) begin fails++; $display("FAIL rs_rv: got %b want 0", rho_valid); end
    if (overrun !== 1'b0) begin fails++; $display("FAIL rs_ovr: got %b want 0", overrun); end
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0);
      tests++;
      if (rho_valid !== 1'b0 || audio_valid !== 1'b0) begin
        fails++; $display("FAIL rs_after%0d: got rv=%b av=%b want 0 0", i, rho_valid, audio_valid);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 2) != 0, int'($urandom_range(0, 262143)),
            (i % 200 < 100) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0),
            $urandom_range(0, 60) == 0);
      tests += 7;
      if (rho_valid !== rv_m) begin fails++; $display("FAIL rnd_rv@%0d: got %b want %b", i, rho_valid, rv_m); end
      if (int'(rho) !== rho_m) begin fails++; $display("FAIL rnd_rho@%0d: got %0d want %0d", i, rho, rho_m); end
      if (int'(rho2) !== rho2_m) begin fails++; $display("FAIL rnd_rho2@%0d: got %0d want %0d", i, rho2, rho2_m); end
      if (audio_valid !== (exp_q.size() > 0)) begin fails++; $display("FAIL rnd_av@%0d: got %b want %b", i, audio_valid, exp_q.size() > 0); end
      if (int'(audio_data) !== (exp_q.size() > 0 ? exp_q[0] : 0)) begin
        fails++; $display("FAIL rnd_ad@%0d: got %0d want %0d", i, audio_data, exp_q.size() > 0 ? exp_q[0] : 0);
      end
      if (overrun !== ovr_m) begin fails++; $display("FAIL rnd_ovr@%0d: got %b want %b", i, overrun, ovr_m); end
      if (grid_enable !== ge_m) begin fails++; $display("FAIL rnd_ge@%0d: got %b want %b", i, grid_enable, ge_m); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_square_clamp();
    test_full();
    test_back_to_back();
    test_restart();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
